// File: rtl/lcd_seq_ctrl.sv
// lcd_seq_ctrl: write-only HD44780-style character-LCD sequencer.
// After a power-up delay it issues four initialisation commands. It then
// serialises byte writes from a single requester onto RS/RW/E/DATA.
//
// Handshake: a request transfers on a rising clk_clk edge where req_valid=1
// and req_ready=1. req_ready is a register and is high only in READY. A
// requester must hold req_valid/req_rs/req_data stable until the transfer.
// Those inputs are ignored at every other time.
module lcd_seq_ctrl #(
  parameter int INIT_WAIT_CYC  = 2_500_000,
  parameter int SETUP_CYC      = 4,
  parameter int E_HIGH_CYC     = 12,
  parameter int CMD_WAIT_CYC   = 2_500,
  parameter int CLEAR_WAIT_CYC = 100_000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam logic [2:0] PWR_WAIT  = 3'd0;
  localparam logic [2:0] SETUP     = 3'd1;
  localparam logic [2:0] E_HIGH    = 3'd2;
  localparam logic [2:0] POST_WAIT = 3'd3;
  localparam logic [2:0] READY     = 3'd4;

  // Every state lasts (load + 1) cycles, so each load value is count-1.
  localparam logic [23:0] INIT_LD  = 24'(INIT_WAIT_CYC - 1);
  localparam logic [23:0] SETUP_LD = 24'(SETUP_CYC - 1);
  localparam logic [23:0] EH_LD    = 24'(E_HIGH_CYC - 1);
  localparam logic [23:0] CMD_LD   = 24'(CMD_WAIT_CYC - 1);
  localparam logic [23:0] CLEAR_LD = 24'(CLEAR_WAIT_CYC - 1);

  logic [2:0]  state;
  logic [23:0] cnt;
  logic [1:0]  init_idx;
  logic [1:0]  next_idx;
  logic        cnt_zero;
  logic        slow_cmd;
  logic [23:0] wait_ld;
  logic        accept;

  // Fixed initialisation command table.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  assign lcd_rw = 1'b0;

  // Derive the exit condition, the post-write wait and the handshake.
  // The bus holds the byte being written, so it selects the wait.
  // Clear/home commands (RS=0, 0x01..0x03) need the long wait.
  always_comb begin
    cnt_zero = (cnt == 24'd0);
    next_idx = init_idx + 2'd1;
    slow_cmd = !lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02 || lcd_data == 8'h03);
    wait_ld  = slow_cmd ? CLEAR_LD : CMD_LD;
    accept   = req_valid && req_ready;
  end

  // Sequencer FSM, shared down-counter and registered LCD/handshake outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= PWR_WAIT;
      cnt       <= INIT_LD;
      init_idx  <= 2'd0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
      lcd_e     <= 1'b0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        PWR_WAIT: begin
          if (cnt_zero) begin
            state    <= SETUP;
            cnt      <= SETUP_LD;
            init_idx <= 2'd0;
            lcd_rs   <= 1'b0;
            lcd_data <= init_cmd(2'd0);
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        SETUP: begin
          if (cnt_zero) begin
            state <= E_HIGH;
            cnt   <= EH_LD;
            lcd_e <= 1'b1;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        E_HIGH: begin
          if (cnt_zero) begin
            state <= POST_WAIT;
            cnt   <= wait_ld;
            lcd_e <= 1'b0;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        POST_WAIT: begin
          if (cnt_zero) begin
            if (!init_done && init_idx != 2'd3) begin
              // Next initialisation command.
              state    <= SETUP;
              cnt      <= SETUP_LD;
              init_idx <= next_idx;
              lcd_rs   <= 1'b0;
              lcd_data <= init_cmd(next_idx);
            end else begin
              state     <= READY;
              req_ready <= 1'b1;
              init_done <= 1'b1;
            end
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        READY: begin
          if (accept) begin
            state     <= SETUP;
            cnt       <= SETUP_LD;
            lcd_rs    <= req_rs;
            lcd_data  <= req_data;
            req_ready <= 1'b0;
          end
        end
        default: begin
          state     <= PWR_WAIT;
          cnt       <= INIT_LD;
          lcd_e     <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Directed testbench for lcd_seq_ctrl with short timing parameters.
module tb_lcd_seq_ctrl;

  localparam int INIT_W  = 10;
  localparam int SETUP_W = 2;
  localparam int EH_W    = 3;
  localparam int CMD_W   = 5;
  localparam int CLR_W   = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready;
  logic       init_done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Observed E pulses.
  int         pulse_start_q[$];
  int         pulse_width_q[$];
  int         pulse_setup_q[$];
  logic [7:0] pulse_data_q[$];
  logic       pulse_rs_q[$];
  logic [7:0] exp_q[$];

  logic       prev_e = 1'b0;
  logic       prev_rs = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         last_change = 0;
  int         e_start = 0;

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_seq_ctrl #(
    .INIT_WAIT_CYC (INIT_W),
    .SETUP_CYC     (SETUP_W),
    .E_HIGH_CYC    (EH_W),
    .CMD_WAIT_CYC  (CMD_W),
    .CLEAR_WAIT_CYC(CLR_W)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .req_valid    (req_valid),
    .req_rs       (req_rs),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .init_done    (init_done),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_e        (lcd_e),
    .lcd_data     (lcd_data)
  );

  // Bus monitor: record pulses and check invariants on every falling edge.
  always @(negedge clk) begin
    checks = checks + 3;
    if (lcd_rw !== 1'b0) begin
      errors++;
      $display("FAIL inv_rw: lcd_rw=%b required 0 at cyc %0d", lcd_rw, cyc);
    end
    if (prev_e && lcd_e && (lcd_data !== prev_data || lcd_rs !== prev_rs)) begin
      errors++;
      $display("FAIL inv_bus_stable: data %h->%h rs %b->%b while E high at cyc %0d",
               prev_data, lcd_data, prev_rs, lcd_rs, cyc);
    end
    if (req_ready === 1'b1 && init_done !== 1'b1) begin
      errors++;
      $display("FAIL inv_ready_init: req_ready=1 init_done=%b required 1 at cyc %0d", init_done, cyc);
    end
    if (lcd_data !== prev_data || lcd_rs !== prev_rs) last_change = cyc;
    if (lcd_e === 1'b1 && !prev_e) begin
      e_start = cyc;
      pulse_start_q.push_back(cyc);
      pulse_data_q.push_back(lcd_data);
      pulse_rs_q.push_back(lcd_rs);
      pulse_setup_q.push_back(cyc - last_change);
    end
    if (lcd_e !== 1'b1 && prev_e) pulse_width_q.push_back(cyc - e_start);
    prev_e    = (lcd_e === 1'b1);
    prev_rs   = lcd_rs;
    prev_data = lcd_data;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    pulse_start_q.delete();
    pulse_width_q.delete();
    pulse_setup_q.delete();
    pulse_data_q.delete();
    pulse_rs_q.delete();
  endtask

  // Returns the sample cycle at which init_done is first seen, or -1.
  task automatic wait_init(output int done_cyc);
    done_cyc = -1;
    for (int n = 0; n < 300; n++) begin
      if (init_done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      step();
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL init_timeout: init_done=%b required 1 within 300 cycles", init_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks = checks + 6;
    if (lcd_e !== 1'b0)     begin errors++; $display("FAIL rst_e: got %b want 0", lcd_e); end
    if (lcd_rs !== 1'b0)    begin errors++; $display("FAIL rst_rs: got %b want 0", lcd_rs); end
    if (lcd_rw !== 1'b0)    begin errors++; $display("FAIL rst_rw: got %b want 0", lcd_rw); end
    if (lcd_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", lcd_data); end
    if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init: got %b want 0", init_done); end
  endtask

  // Release reset, then check the four init writes and their spacing.
  // Rises (edges after release): 10+2=12, +3+5+2=22, 32, then +3+20+2=57.
  // The last write ends at 57+3+5=65.
  task automatic test_power_up(input string name);
    int r;
    int d;
    int exp_start[4];
    clear_pulses();
    exp_q = '{8'h38, 8'h0C, 8'h01, 8'h06};
    rst_n = 1'b1;
    r = cyc;
    exp_start = '{r + 12, r + 22, r + 32, r + 57};
    wait_init(d);
    checks = checks + 3;
    if (d != r + 65) begin errors++; $display("FAIL %s_done_cyc: got %0d want %0d", name, d - r, 65); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_with_init: got %b want 1", name, req_ready); end
    if (pulse_start_q.size() != 4 || pulse_width_q.size() != 4) begin
      errors++;
      $display("FAIL %s_pulse_count: got %0d want 4", name, pulse_start_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks = checks + 4;
        if (pulse_data_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s_data%0d: got %h want %h", name, i, pulse_data_q[i], exp_q[i]); end
        if (pulse_rs_q[i] !== 1'b0) begin errors++; $display("FAIL %s_rs%0d: got %b want 0", name, i, pulse_rs_q[i]); end
        if (pulse_width_q[i] != EH_W) begin errors++; $display("FAIL %s_width%0d: got %0d want %0d", name, i, pulse_width_q[i], EH_W); end
        if (pulse_start_q[i] != exp_start[i]) begin errors++; $display("FAIL %s_start%0d: got %0d want %0d", name, i, pulse_start_q[i] - r, exp_start[i] - r); end
      end
    end
  endtask

  // One request from READY: check setup, pulse shape and ready latency.
  task automatic test_write(input logic rs, input logic [7:0] data, input int exp_lat, input string name);
    int acc;
    int back;
    clear_pulses();
    acc = -1;
    back = -1;
    req_valid = 1'b1;
    req_rs = rs;
    req_data = data;
    for (int n = 0; n < 50; n++) begin
      if (req_ready === 1'b1) begin
        step();
        acc = cyc;
        break;
      end
      step();
    end
    // Scrambled inputs after acceptance must not reach the bus.
    req_valid = 1'b0;
    req_rs = ~rs;
    req_data = ~data;
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL %s_accept_timeout: req_ready=%b want 1", name, req_ready);
      return;
    end
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL %s_ready_drop: got %b want 0", name, req_ready); end
    for (int n = 0; n < 100; n++) begin
      if (req_ready === 1'b1) begin
        back = cyc;
        break;
      end
      step();
    end
    checks++;
    if (back - acc != exp_lat) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, back - acc, exp_lat); end
    checks++;
    if (pulse_start_q.size() != 1 || pulse_width_q.size() != 1) begin
      errors++;
      $display("FAIL %s_pulse_count: got %0d want 1", name, pulse_start_q.size());
    end else begin
      checks = checks + 5;
      if (pulse_data_q[0] !== data) begin errors++; $display("FAIL %s_data: got %h want %h", name, pulse_data_q[0], data); end
      if (pulse_rs_q[0] !== rs) begin errors++; $display("FAIL %s_rs: got %b want %b", name, pulse_rs_q[0], rs); end
      if (pulse_width_q[0] != EH_W) begin errors++; $display("FAIL %s_width: got %0d want %0d", name, pulse_width_q[0], EH_W); end
      if (pulse_setup_q[0] != SETUP_W) begin errors++; $display("FAIL %s_setup: got %0d want %0d", name, pulse_setup_q[0], SETUP_W); end
      if (pulse_start_q[0] != acc + SETUP_W) begin errors++; $display("FAIL %s_start: got %0d want %0d", name, pulse_start_q[0] - acc, SETUP_W); end
    end
  endtask

  // req_valid held from reset release: no extra pulse during init. The
  // request goes on the first READY cycle; the next follows with no idle gap.
  task automatic test_back_to_back();
    int d;
    int acc1;
    int acc2;
    rst_n = 1'b0;
    step();
    step();
    req_valid = 1'b1;
    req_rs = 1'b1;
    req_data = 8'h55;
    clear_pulses();
    rst_n = 1'b1;
    wait_init(d);
    checks++;
    if (pulse_start_q.size() != 4) begin errors++; $display("FAIL b2b_init_pulses: got %0d want 4", pulse_start_q.size()); end
    step();
    acc1 = cyc;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_first_accept: req_ready=%b want 0 one cycle after init_done", req_ready); end
    req_data = 8'h66;
    acc2 = -1;
    for (int n = 0; n < 50; n++) begin
      if (req_ready === 1'b1) begin
        step();
        acc2 = cyc;
        break;
      end
      step();
    end
    req_valid = 1'b0;
    req_data = 8'h00;
    for (int n = 0; n < 50; n++) begin
      if (req_ready === 1'b1) break;
      step();
    end
    checks = checks + 2;
    // The ready rises 10 cycles after acc1; the next edge accepts.
    if (acc2 - acc1 != SETUP_W + EH_W + CMD_W + 1) begin
      errors++;
      $display("FAIL b2b_accept_gap: got %0d want %0d", acc2 - acc1, SETUP_W + EH_W + CMD_W + 1);
    end
    if (pulse_start_q.size() != 6) begin
      errors++;
      $display("FAIL b2b_pulse_count: got %0d want 6", pulse_start_q.size());
    end else begin
      checks = checks + 4;
      if (pulse_data_q[4] !== 8'h55) begin errors++; $display("FAIL b2b_data0: got %h want 55", pulse_data_q[4]); end
      if (pulse_data_q[5] !== 8'h66) begin errors++; $display("FAIL b2b_data1: got %h want 66", pulse_data_q[5]); end
      if (pulse_start_q[4] != d + 1 + SETUP_W) begin errors++; $display("FAIL b2b_start0: got %0d want %0d", pulse_start_q[4] - d, 1 + SETUP_W); end
      if (pulse_start_q[5] - pulse_start_q[4] != SETUP_W + EH_W + CMD_W + 1) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d want %0d", pulse_start_q[5] - pulse_start_q[4], SETUP_W + EH_W + CMD_W + 1);
      end
    end
  endtask

  // Reset while E is high: outputs clear before the next edge, then init restarts.
  task automatic test_reset_mid_pulse();
    int seen;
    seen = 0;
    req_valid = 1'b1;
    req_rs = 1'b1;
    req_data = 8'h77;
    for (int n = 0; n < 50; n++) begin
      if (lcd_e === 1'b1) begin
        seen = 1;
        break;
      end
      step();
    end
    req_valid = 1'b0;
    checks++;
    if (seen == 0) begin errors++; $display("FAIL midrst_no_pulse: lcd_e=%b want 1", lcd_e); end
    rst_n = 1'b0;
    #1;
    checks = checks + 5;
    if (lcd_e !== 1'b0)     begin errors++; $display("FAIL midrst_e: got %b want 0", lcd_e); end
    if (lcd_rs !== 1'b0)    begin errors++; $display("FAIL midrst_rs: got %b want 0", lcd_rs); end
    if (lcd_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", lcd_data); end
    if (req_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", req_ready); end
    if (init_done !== 1'b0) begin errors++; $display("FAIL midrst_init: got %b want 0", init_done); end
    step();
    step();
    test_power_up("midrst_reinit");
  endtask

  initial begin
    test_reset();
    test_power_up("pwrup");
    test_write(1'b1, 8'h41, SETUP_W + EH_W + CMD_W, "data_41");
    test_write(1'b0, 8'h01, SETUP_W + EH_W + CLR_W, "clear_01");
    test_write(1'b0, 8'h03, SETUP_W + EH_W + CLR_W, "home_03");
    test_write(1'b1, 8'h01, SETUP_W + EH_W + CMD_W, "data_01");
    test_write(1'b0, 8'h02, SETUP_W + EH_W + CLR_W, "home_02");
    test_write(1'b0, 8'h04, SETUP_W + EH_W + CMD_W, "cmd_04");
    test_back_to_back();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
